// File: rtl/rotary_debounce.sv
// -----------------------------------------------------------------------------
// rotary_debounce
//
// Conditions the rotary encoder pins before they reach the quadrature decoder.
// Each of the three raw pins (A, B, push) gets its own 2-flop synchroniser,
// its own stability counter and its own debounced output register. The
// channels do not interact. The push channel also produces a one-cycle pulse
// on each debounced press (0->1).
//
// Parameters
//   STABLE_CYCLES : consecutive synchronised cycles an input must disagree
//                   with its debounced output before that output flips (>=1)
//   CNT_W         : counter width, derived from STABLE_CYCLES (do not override)
//
// Ports
//   clk             : system clock, all registers on its rising edge
//   reset           : synchronous, active-high reset
//   rotary_a_raw    : encoder channel A pin (asynchronous)
//   rotary_b_raw    : encoder channel B pin (asynchronous)
//   rotary_push_raw : encoder push switch pin (asynchronous, active-high)
//   rotary_inc_a    : debounced channel A (registered)
//   rotary_inc_b    : debounced channel B (registered)
//   rotary_push     : debounced push level (registered)
//   push_pressed    : one-cycle pulse per debounced press (registered)
// -----------------------------------------------------------------------------
module rotary_debounce #(
    parameter int STABLE_CYCLES = 100000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic rotary_a_raw,
    input  logic rotary_b_raw,
    input  logic rotary_push_raw,
    output logic rotary_inc_a,
    output logic rotary_inc_b,
    output logic rotary_push,
    output logic push_pressed
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(STABLE_CYCLES - 1);

    // Channel order: 0 = A, 1 = B, 2 = push.
    logic [2:0] raw_pins;
    logic [2:0] deb_q;   // debounced levels, current
    logic [2:0] deb_d;   // debounced levels, next

    assign raw_pins = {rotary_push_raw, rotary_b_raw, rotary_a_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic             s1_q, s1_d;
            logic             s2_q, s2_d;
            logic             out_q, out_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                s1_d  = raw_pins[gi];
                s2_d  = s1_q;
                out_d = out_q;
                cnt_d = '0;
                // Any agreement between s2 and out clears the count, so a
                // bounce shorter than STABLE_CYCLES never reaches out.
                if (s2_q != out_q) begin
                    if (cnt_q == TERM_CNT) begin
                        out_d = s2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_q  <= 1'b0;
                    s2_q  <= 1'b0;
                    out_q <= 1'b0;
                    cnt_q <= '0;
                end else begin
                    s1_q  <= s1_d;
                    s2_q  <= s2_d;
                    out_q <= out_d;
                    cnt_q <= cnt_d;
                end
            end

            assign deb_q[gi] = out_q;
            assign deb_d[gi] = out_d;
        end
    endgenerate

    // Pulse register fires on the same edge the push output rises, so the
    // pulse is coincident with the first cycle of rotary_push high.
    logic push_pressed_q, push_pressed_d;

    assign push_pressed_d = ~deb_q[2] & deb_d[2];

    always_ff @(posedge clk) begin
        if (reset) begin
            push_pressed_q <= 1'b0;
        end else begin
            push_pressed_q <= push_pressed_d;
        end
    end

    assign rotary_inc_a = deb_q[0];
    assign rotary_inc_b = deb_q[1];
    assign rotary_push  = deb_q[2];
    assign push_pressed = push_pressed_q;

endmodule

// File: tb/tb_rotary_debounce.sv
// -----------------------------------------------------------------------------
// tb_rotary_debounce
//
// Directed scenarios followed by randomized pin activity. Expected outputs come
// from a history-based reference: the synchronised value seen at edge n is the
// raw pin sampled two edges earlier (zero near reset), and an output flips at
// edge n when the last STABLE_CYCLES synchronised samples all disagree with it
// and no flip or reset happened inside that window.
// -----------------------------------------------------------------------------
module tb_rotary_debounce;

    localparam int S    = 4;
    localparam int NMAX = 4096;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rotary_a_raw = 1'b0;
    logic rotary_b_raw = 1'b0;
    logic rotary_push_raw = 1'b0;
    logic rotary_inc_a, rotary_inc_b, rotary_push, push_pressed;

    rotary_debounce #(.STABLE_CYCLES(S)) dut (
        .clk             (clk),
        .reset           (reset),
        .rotary_a_raw    (rotary_a_raw),
        .rotary_b_raw    (rotary_b_raw),
        .rotary_push_raw (rotary_push_raw),
        .rotary_inc_a    (rotary_inc_a),
        .rotary_inc_b    (rotary_inc_b),
        .rotary_push     (rotary_push),
        .push_pressed    (push_pressed)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pp_cnt = 0;

    bit rst_h [NMAX];
    bit raw_h [3][NMAX];
    bit out_m [3];
    int last_evt [3];
    bit pp_m;

    // Synchronised value the debouncer compares at edge n.
    function automatic bit eff(input int ch, input int n);
        if (n < 2) return 1'b0;
        if (rst_h[n-1] || rst_h[n-2]) return 1'b0;
        return raw_h[ch][n-2];
    endfunction

    task automatic chk(input string tag, input logic got, input bit exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit a, input bit b, input bit p);
        bit flip;
        bit prev_push;
        @(negedge clk);
        reset = r;
        rotary_a_raw = a;
        rotary_b_raw = b;
        rotary_push_raw = p;
        @(posedge clk);
        rst_h[cyc]    = r;
        raw_h[0][cyc] = a;
        raw_h[1][cyc] = b;
        raw_h[2][cyc] = p;
        prev_push = out_m[2];
        for (int ch = 0; ch < 3; ch++) begin
            if (r) begin
                out_m[ch]    = 1'b0;
                last_evt[ch] = cyc;
            end else if (cyc - last_evt[ch] >= S) begin
                flip = 1'b1;
                for (int k = cyc - S + 1; k <= cyc; k++)
                    if (eff(ch, k) == out_m[ch]) flip = 1'b0;
                if (flip) begin
                    out_m[ch]    = ~out_m[ch];
                    last_evt[ch] = cyc;
                end
            end
        end
        pp_m = !r && !prev_push && out_m[2];
        #1;
        chk("inc_a", rotary_inc_a, out_m[0]);
        chk("inc_b", rotary_inc_b, out_m[1]);
        chk("push", rotary_push, out_m[2]);
        chk("push_pressed", push_pressed, pp_m);
        $display("cyc=%0d rst=%b raw=%b%b%b out=%b%b%b pp=%b", cyc, r, a, b, p,
                 rotary_inc_a, rotary_inc_b, rotary_push, push_pressed);
        if (push_pressed === 1'b1) pp_cnt++;
        cyc++;
    endtask

    task automatic hold(input int n, input bit r, input bit a, input bit b, input bit p);
        for (int i = 0; i < n; i++) step(r, a, b, p);
    endtask

    initial begin
        bit ra, rb, rp, rr;
        int la, lb, lp;
        for (int ch = 0; ch < 3; ch++) begin
            out_m[ch]    = 1'b0;
            last_evt[ch] = 0;
        end
        pp_m = 1'b0;

        // Reset with all pins high, then release: all outputs rise together.
        hold(3, 1, 1, 1, 1);
        chk("reset_a", rotary_inc_a, 1'b0);
        chk("reset_p", rotary_push, 1'b0);
        pp_cnt = 0;
        hold(10, 0, 1, 1, 1);
        total++;
        assert (pp_cnt === 1) else begin
            bad++;
            $error("FAIL pulse_after_reset got=%0d exp=1", pp_cnt);
        end

        // Return to idle, then clean A step.
        hold(10, 0, 0, 0, 0);
        hold(12, 0, 1, 0, 0);

        // Bounce on A then settle high.
        hold(10, 0, 0, 0, 0);
        step(0, 1, 0, 0); step(0, 0, 0, 0); step(0, 1, 0, 0); step(0, 0, 0, 0);
        hold(10, 0, 1, 0, 0);
        hold(10, 0, 0, 0, 0);

        // Push press and release: exactly one pulse.
        pp_cnt = 0;
        hold(20, 0, 0, 0, 1);
        hold(12, 0, 0, 0, 0);
        total++;
        assert (pp_cnt === 1) else begin
            bad++;
            $error("FAIL press_pulses got=%0d exp=1", pp_cnt);
        end

        // Quadrature detent 00 -> 10 -> 11 -> 01 -> 00.
        hold(10, 0, 1, 0, 0);
        hold(10, 0, 1, 1, 0);
        hold(10, 0, 0, 1, 0);
        hold(10, 0, 0, 0, 0);

        // Reset mid-debounce with A held high.
        hold(3, 0, 1, 0, 0);
        step(1, 1, 0, 0);
        hold(10, 0, 1, 0, 0);
        hold(10, 0, 0, 0, 0);

        // Randomized activity: each pin holds a level for a random run length.
        ra = 0; rb = 0; rp = 0; la = 0; lb = 0; lp = 0;
        for (int i = 0; i < 800; i++) begin
            if (la == 0) begin ra = 1'($urandom); la = $urandom_range(1, 8); end
            if (lb == 0) begin rb = 1'($urandom); lb = $urandom_range(1, 8); end
            if (lp == 0) begin rp = 1'($urandom); lp = $urandom_range(1, 8); end
            rr = ($urandom_range(0, 199) == 0);
            step(rr, ra, rb, rp);
            la--; lb--; lp--;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
